sram_arbiter: RTL and testbench



---
 rtl/sram_arbiter_pkg.sv | 36 +++
 rtl/sram_arbiter_if.sv | 59 +++++
 rtl/sram_arbiter_rr_arbiter2.sv | 38 +++
 rtl/sram_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_sram_arbiter.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/sram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// sram_arbiter_pkg : state/requester encodings and strobe-length helper
// Revision: 1.0 - initial release
// ============================================================================
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  typedef enum logic {
    CPU = 1'b0,
    GPU = 1'b1
  } reqId_t;

  localparam int c_WAIT_MIN = 1;
  localparam int c_WAIT_MAX = 15;
  localparam int c_CNT_W    = 4;

  // Strobe counter load value; out-of-range WAIT_CYCLES is clamped to the legal range.
  function automatic logic [c_CNT_W-1:0] waitLoad(input int waitCycles);
    if (waitCycles <= c_WAIT_MIN) begin
      return '0;
    end else if (waitCycles >= c_WAIT_MAX) begin
      return c_CNT_W'(c_WAIT_MAX - 1);
    end else begin
      return c_CNT_W'(waitCycles - 1);
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_arbiter_if.sv
`default_nettype none
// ============================================================================
// sram_arbiter_if : CPU/GPU request ports and SRAM pin bundle
// Revision: 1.0 - initial release
// ============================================================================
interface sram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [1:0]        cpu_be;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_done;
  logic [DATA_W-1:0] cpu_rdata;

  logic              gpu_req;
  logic              gpu_we;
  logic [1:0]        gpu_be;
  logic [ADDR_W-1:0] gpu_addr;
  logic [DATA_W-1:0] gpu_wdata;
  logic              gpu_gnt;
  logic              gpu_done;
  logic [DATA_W-1:0] gpu_rdata;

  logic              busy;
  logic              CE;
  logic              OE;
  logic              WR;
  logic              UB;
  logic              LB;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] D_out;
  logic              D_oe;
  logic [DATA_W-1:0] D_in;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    input  gpu_req, gpu_we, gpu_be, gpu_addr, gpu_wdata,
    input  D_in,
    output cpu_gnt, cpu_done, cpu_rdata,
    output gpu_gnt, gpu_done, gpu_rdata,
    output busy, CE, OE, WR, UB, LB, A, D_out, D_oe
  );

  // Requester / SRAM side
  modport master (
    output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    output gpu_req, gpu_we, gpu_be, gpu_addr, gpu_wdata,
    output D_in,
    input  cpu_gnt, cpu_done, cpu_rdata,
    input  gpu_gnt, gpu_done, gpu_rdata,
    input  busy, CE, OE, WR, UB, LB, A, D_out, D_oe
  );
endinterface
`default_nettype wire

// File: rtl/sram_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// rr_arbiter2 : two-input round-robin picker, last winner loses the next tie
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import sram_arbiter_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic       o_valid,
  output reqId_t     o_id
);

  reqId_t r_lastGnt;

  always_comb begin
    o_valid = i_en && (i_req != 2'b00);
    o_id    = CPU;
    case (i_req)
      2'b10:   o_id = GPU;
      2'b11:   o_id = (r_lastGnt == GPU) ? CPU : GPU;
      default: o_id = CPU;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_lastGnt <= GPU;
    end else if (o_valid) begin
      r_lastGnt <= o_id;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// sram_arbiter : shares one async 16-bit SRAM between CPU and GPU ports,
//                sequencing SETUP / STROBE / HOLD with fully registered pins
// Revision: 1.0 - initial release
// ============================================================================
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          CLK,
  input  logic          RST,
  sram_arbiter_if.slave bus
);

  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

  state_t              r_state;
  state_t              w_nextState;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [c_CNT_W-1:0]  w_nextCnt;

  reqId_t              r_owner;
  logic                r_we;
  logic [1:0]          r_be;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;

  logic                r_cpuGnt,  w_cpuGnt;
  logic                r_gpuGnt,  w_gpuGnt;
  logic                r_cpuDone, w_cpuDone;
  logic                r_gpuDone, w_gpuDone;
  logic [DATA_W-1:0]   r_cpuRdata;
  logic [DATA_W-1:0]   r_gpuRdata;
  logic                w_capture;
  logic                r_busy;

  logic                r_ce,   w_ce;
  logic                r_oe,   w_oe;
  logic                r_wr,   w_wr;
  logic                r_ub,   w_ub;
  logic                r_lb,   w_lb;
  logic [ADDR_W-1:0]   r_a,    w_a;
  logic [DATA_W-1:0]   r_dOut, w_dOut;
  logic                r_dOe,  w_dOe;

  logic                w_arbEn;
  logic                w_arbValid;
  reqId_t              w_arbId;

  // Grants are registered, so the decision is taken on the edge that enters
  // IDLE (from HOLD) or in an IDLE cycle with no grant already outstanding.
  assign w_arbEn = ((r_state == IDLE) && !(r_cpuGnt || r_gpuGnt)) || (r_state == HOLD);

  rr_arbiter2 u_arb (
    .CLK     (CLK),
    .RST     (RST),
    .i_en    (w_arbEn),
    .i_req   ({bus.gpu_req, bus.cpu_req}),
    .o_valid (w_arbValid),
    .o_id    (w_arbId)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_cpuGnt    = 1'b0;
    w_gpuGnt    = 1'b0;
    w_cpuDone   = 1'b0;
    w_gpuDone   = 1'b0;
    w_capture   = 1'b0;
    w_ce        = 1'b1;
    w_oe        = 1'b1;
    w_wr        = 1'b1;
    w_ub        = 1'b1;
    w_lb        = 1'b1;
    w_a         = r_a;
    w_dOut      = r_dOut;
    w_dOe       = 1'b0;

    case (r_state)
      IDLE: begin
        if (r_cpuGnt || r_gpuGnt) begin
          w_nextState = SETUP;
        end
      end
      SETUP: begin
        w_nextState = STROBE;
        w_nextCnt   = waitLoad(WAIT_CYCLES);
      end
      STROBE: begin
        if (r_cnt == '0) begin
          w_nextState = HOLD;
          w_capture   = 1'b1;
        end else begin
          w_nextCnt = r_cnt - c_CNT_ONE;
        end
      end
      HOLD: begin
        w_nextState = IDLE;
      end
    endcase

    if (w_arbValid) begin
      w_cpuGnt = (w_arbId == CPU);
      w_gpuGnt = (w_arbId == GPU);
    end

    if (w_capture) begin
      w_cpuDone = (r_owner == CPU);
      w_gpuDone = (r_owner == GPU);
    end

    // Pin values are decoded from the state being entered so they line up with it.
    if (w_nextState != IDLE) begin
      w_ce  = 1'b0;
      w_a   = r_addr;
      w_ub  = ~r_be[1];
      w_lb  = ~r_be[0];
      w_dOe = r_we;
      if (r_we) begin
        w_dOut = r_wdata;
      end
    end
    if ((w_nextState inside {SETUP, STROBE}) && !r_we) begin
      w_oe = 1'b0;
    end
    if ((w_nextState == STROBE) && r_we) begin
      w_wr = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_owner    <= GPU;
      r_we       <= 1'b0;
      r_be       <= 2'b00;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cpuGnt   <= 1'b0;
      r_gpuGnt   <= 1'b0;
      r_cpuDone  <= 1'b0;
      r_gpuDone  <= 1'b0;
      r_cpuRdata <= '0;
      r_gpuRdata <= '0;
      r_busy     <= 1'b0;
      r_ce       <= 1'b1;
      r_oe       <= 1'b1;
      r_wr       <= 1'b1;
      r_ub       <= 1'b1;
      r_lb       <= 1'b1;
      r_a        <= '0;
      r_dOut     <= '0;
      r_dOe      <= 1'b0;
    end else begin
      if (w_arbValid) begin
        r_owner <= w_arbId;
        r_we    <= (w_arbId == GPU) ? bus.gpu_we    : bus.cpu_we;
        r_be    <= (w_arbId == GPU) ? bus.gpu_be    : bus.cpu_be;
        r_addr  <= (w_arbId == GPU) ? bus.gpu_addr  : bus.cpu_addr;
        r_wdata <= (w_arbId == GPU) ? bus.gpu_wdata : bus.cpu_wdata;
      end
      if (w_capture && !r_we) begin
        if (r_owner == CPU) begin
          r_cpuRdata <= bus.D_in;
        end else begin
          r_gpuRdata <= bus.D_in;
        end
      end
      r_cpuGnt  <= w_cpuGnt;
      r_gpuGnt  <= w_gpuGnt;
      r_cpuDone <= w_cpuDone;
      r_gpuDone <= w_gpuDone;
      r_busy    <= (w_nextState != IDLE);
      r_ce      <= w_ce;
      r_oe      <= w_oe;
      r_wr      <= w_wr;
      r_ub      <= w_ub;
      r_lb      <= w_lb;
      r_a       <= w_a;
      r_dOut    <= w_dOut;
      r_dOe     <= w_dOe;
    end
  end

  assign bus.cpu_gnt   = r_cpuGnt;
  assign bus.gpu_gnt   = r_gpuGnt;
  assign bus.cpu_done  = r_cpuDone;
  assign bus.gpu_done  = r_gpuDone;
  assign bus.cpu_rdata = r_cpuRdata;
  assign bus.gpu_rdata = r_gpuRdata;
  assign bus.busy      = r_busy;
  assign bus.CE        = r_ce;
  assign bus.OE        = r_oe;
  assign bus.WR        = r_wr;
  assign bus.UB        = r_ub;
  assign bus.LB        = r_lb;
  assign bus.A         = r_a;
  assign bus.D_out     = r_dOut;
  assign bus.D_oe      = r_dOe;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_sram_arbiter : directed bench, WAIT_CYCLES=1 and WAIT_CYCLES=3 instances
// Revision: 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  int nAssert = 0;
  int nFail   = 0;

  sram_arbiter_if #(.ADDR_W(16), .DATA_W(16)) b1 ();
  sram_arbiter_if #(.ADDR_W(16), .DATA_W(16)) b3 ();

  sram_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(1)) dut1 (.CLK(CLK), .RST(RST), .bus(b1));
  sram_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(3)) dut3 (.CLK(CLK), .RST(RST), .bus(b3));

  // Async SRAM models: a write commits when WR rises with CE still low.
  logic [15:0] mem1 [0:65535] = '{default: 16'h0};
  logic [15:0] mem3 [0:65535] = '{default: 16'h0};
  logic        pend1 = 1'b0, pend3 = 1'b0;
  logic [15:0] pendA1, pendD1, pendA3, pendD3;
  logic        pendUb1, pendLb1, pendUb3, pendLb3;

  assign b1.D_in = (!b1.CE && !b1.OE) ? mem1[b1.A] : 16'h0000;
  assign b3.D_in = (!b3.CE && !b3.OE) ? mem3[b3.A] : 16'h0000;

  always @(negedge CLK) begin
    if (pend1 && b1.WR && !b1.CE)
      mem1[pendA1] <= {pendUb1 ? pendD1[15:8] : mem1[pendA1][15:8],
                       pendLb1 ? pendD1[7:0]  : mem1[pendA1][7:0]};
    pend1   <= !b1.WR && !b1.CE && b1.D_oe;
    pendA1  <= b1.A;
    pendD1  <= b1.D_out;
    pendUb1 <= !b1.UB;
    pendLb1 <= !b1.LB;
  end

  always @(negedge CLK) begin
    if (pend3 && b3.WR && !b3.CE)
      mem3[pendA3] <= {pendUb3 ? pendD3[15:8] : mem3[pendA3][15:8],
                       pendLb3 ? pendD3[7:0]  : mem3[pendA3][7:0]};
    pend3   <= !b3.WR && !b3.CE && b3.D_oe;
    pendA3  <= b3.A;
    pendD3  <= b3.D_out;
    pendUb3 <= !b3.UB;
    pendLb3 <= !b3.LB;
  end

  // Per-cycle traces, bit k = negedge k after the request was raised.
  logic [15:0] tCGnt, tGGnt, tCDone, tGDone, tWrL, tOeL, tDoe, tCeL, tUbL, tLbL, tBusy;
  logic [15:0] t3Gnt, t3OeL, t3Done;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nAssert++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clearTrace();
    tCGnt = '0; tGGnt = '0; tCDone = '0; tGDone = '0; tWrL = '0; tOeL = '0;
    tDoe  = '0; tCeL  = '0; tUbL   = '0; tLbL   = '0; tBusy = '0;
    t3Gnt = '0; t3OeL = '0; t3Done = '0;
  endtask

  task automatic capture(input int k);
    tCGnt[k]  = b1.cpu_gnt;  tGGnt[k]  = b1.gpu_gnt;
    tCDone[k] = b1.cpu_done; tGDone[k] = b1.gpu_done;
    tWrL[k]   = ~b1.WR;      tOeL[k]   = ~b1.OE;
    tDoe[k]   = b1.D_oe;     tCeL[k]   = ~b1.CE;
    tUbL[k]   = ~b1.UB;      tLbL[k]   = ~b1.LB;
    tBusy[k]  = b1.busy;
    t3Gnt[k]  = b3.cpu_gnt;  t3OeL[k]  = ~b3.OE;  t3Done[k] = b3.cpu_done;
  endtask

  // Called at a negedge; runs one access on the WAIT_CYCLES=1 instance.
  task automatic access1(input bit gpu, input logic we, input logic [1:0] be,
                         input logic [15:0] addr, input logic [15:0] wdata);
    clearTrace();
    if (gpu) begin
      b1.gpu_req = 1'b1; b1.gpu_we = we; b1.gpu_be = be; b1.gpu_addr = addr; b1.gpu_wdata = wdata;
    end else begin
      b1.cpu_req = 1'b1; b1.cpu_we = we; b1.cpu_be = be; b1.cpu_addr = addr; b1.cpu_wdata = wdata;
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      capture(k);
      if (b1.cpu_gnt) b1.cpu_req = 1'b0;
      if (b1.gpu_gnt) b1.gpu_req = 1'b0;
    end
    b1.cpu_req = 1'b0;
    b1.gpu_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nG;
    b1.cpu_req = 0; b1.cpu_we = 0; b1.cpu_be = 0; b1.cpu_addr = 0; b1.cpu_wdata = 0;
    b1.gpu_req = 0; b1.gpu_we = 0; b1.gpu_be = 0; b1.gpu_addr = 0; b1.gpu_wdata = 0;
    b3.cpu_req = 0; b3.cpu_we = 0; b3.cpu_be = 0; b3.cpu_addr = 0; b3.cpu_wdata = 0;
    b3.gpu_req = 0; b3.gpu_we = 0; b3.gpu_be = 0; b3.gpu_addr = 0; b3.gpu_wdata = 0;
    clearTrace();

    RST = 1'b1;
    repeat (3) @(negedge CLK);
    checkVal("rst_strobes", {b1.CE, b1.OE, b1.WR, b1.UB, b1.LB}, 32'h1F);
    checkVal("rst_doe", b1.D_oe, 0);
    checkVal("rst_addr_dout", {b1.A, b1.D_out}, 0);
    checkVal("rst_busy", b1.busy, 0);
    checkVal("rst_gnt_done", {b1.cpu_gnt, b1.cpu_done, b1.gpu_gnt, b1.gpu_done}, 0);
    checkVal("rst_rdata", {b1.cpu_rdata, b1.gpu_rdata}, 0);
    RST = 1'b0;
    @(negedge CLK);

    // CPU full write then read, WAIT_CYCLES=1
    access1(0, 1'b1, 2'b11, 16'h1234, 16'hA5C3);
    checkVal("wr_gnt", tCGnt, 16'h0001);
    checkVal("wr_wr_low", tWrL, 16'h0004);
    checkVal("wr_done", tCDone, 16'h0008);
    checkVal("wr_oe_low", tOeL, 16'h0000);
    checkVal("wr_doe", tDoe, 16'h000E);
    checkVal("wr_ce_low", tCeL, 16'h000E);
    checkVal("wr_busy", tBusy, 16'h000E);
    checkVal("wr_mem", mem1[16'h1234], 16'hA5C3);

    access1(0, 1'b0, 2'b11, 16'h1234, 16'h0000);
    checkVal("rd_gnt", tCGnt, 16'h0001);
    checkVal("rd_oe_low", tOeL, 16'h0006);
    checkVal("rd_doe", tDoe, 16'h0000);
    checkVal("rd_wr_low", tWrL, 16'h0000);
    checkVal("rd_done", tCDone, 16'h0008);
    checkVal("rd_rdata", b1.cpu_rdata, 16'hA5C3);

    // GPU byte write into upper half only
    access1(1, 1'b1, 2'b11, 16'h0002, 16'h1234);
    access1(1, 1'b1, 2'b10, 16'h0002, 16'hFF00);
    checkVal("bw_ub_low", tUbL, 16'h000E);
    checkVal("bw_lb_low", tLbL, 16'h0000);
    checkVal("bw_gpu_done", tGDone, 16'h0008);
    checkVal("bw_cpu_done", tCDone, 16'h0000);
    checkVal("bw_mem", mem1[16'h0002], 16'hFF34);
    access1(1, 1'b0, 2'b11, 16'h0002, 16'h0000);
    checkVal("bw_gpu_rdata", b1.gpu_rdata, 16'hFF34);
    checkVal("bw_cpu_rdata_kept", b1.cpu_rdata, 16'hA5C3);

    // Simultaneous requests from reset: CPU first, then alternate
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    clearTrace();
    b1.cpu_we = 0; b1.cpu_be = 2'b11; b1.cpu_addr = 16'h0100; b1.cpu_req = 1'b1;
    b1.gpu_we = 0; b1.gpu_be = 2'b11; b1.gpu_addr = 16'h0200; b1.gpu_req = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge CLK);
      capture(k);
    end
    b1.cpu_req = 1'b0;
    b1.gpu_req = 1'b0;
    checkVal("tie_cpu_gnt", tCGnt, 16'h0101);
    checkVal("tie_gpu_gnt", tGGnt, 16'h1010);
    repeat (6) @(negedge CLK);

    // Reset during the strobe of a write must drop it cleanly
    access1(0, 1'b1, 2'b11, 16'h0010, 16'h1111);
    b1.cpu_req = 1'b1; b1.cpu_we = 1'b1; b1.cpu_be = 2'b11;
    b1.cpu_addr = 16'h0010; b1.cpu_wdata = 16'hBEEF;
    @(negedge CLK);
    checkVal("abort_gnt", b1.cpu_gnt, 1);
    b1.cpu_req = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    checkVal("abort_in_strobe", {b1.CE, b1.WR}, 2'b00);
    RST = 1'b1;
    @(negedge CLK);
    checkVal("abort_ce_wr", {b1.CE, b1.WR}, 2'b11);
    checkVal("abort_doe", b1.D_oe, 0);
    checkVal("abort_no_done", b1.cpu_done, 0);
    RST = 1'b0;
    @(negedge CLK);
    checkVal("abort_no_late_done", b1.cpu_done, 0);
    access1(0, 1'b0, 2'b11, 16'h0010, 16'h0000);
    checkVal("abort_rd_rdata", b1.cpu_rdata, 16'h1111);

    // WAIT_CYCLES=3 instance: write, then back-to-back reads
    b3.cpu_req = 1'b1; b3.cpu_we = 1'b1; b3.cpu_be = 2'b11;
    b3.cpu_addr = 16'h0040; b3.cpu_wdata = 16'h5A5A;
    @(negedge CLK);
    checkVal("w3_gnt", b3.cpu_gnt, 1);
    b3.cpu_req = 1'b0;
    repeat (8) @(negedge CLK);
    checkVal("w3_mem", mem3[16'h0040], 16'h5A5A);

    clearTrace();
    nG = 0;
    b3.cpu_we = 1'b0;
    b3.cpu_req = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge CLK);
      capture(k);
      if (b3.cpu_gnt) begin
        nG++;
        if (nG == 2) b3.cpu_req = 1'b0;
      end
    end
    b3.cpu_req = 1'b0;
    checkVal("w3_rd_gnt", t3Gnt, 16'h0041);
    checkVal("w3_rd_oe_low", t3OeL, 16'h079E);
    checkVal("w3_rd_done", t3Done, 16'h0820);
    checkVal("w3_rd_rdata", b3.cpu_rdata, 16'h5A5A);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
`default_nettype wire
